// File: rtl/rf_op_sequencer_if.sv
// -----------------------------------------------------------------------------
// rf_op_sequencer_if
// Bundles the command handshake and the register-file bus of rf_op_sequencer.
//
// Parameters
//   DATA_W  datapath / register file data width
//   ADDR_W  register address width
//
// Signals
//   cmd_valid, cmd_ready          command handshake
//   cmd_op, cmd_rd, cmd_rs,
//   cmd_imm                       command payload
//   rf_read_addr_a/_b             register file read addresses
//   rf_read_data_a/_b             register file read data (asynchronous read)
//   rf_write_addr/_data/_en       register file write port
//
// Modports
//   master  command issuer plus the register file itself (the environment)
//   slave   the sequencer
// -----------------------------------------------------------------------------
interface rf_op_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_rd;
    logic [ADDR_W-1:0] cmd_rs;
    logic [DATA_W-1:0] cmd_imm;

    logic [ADDR_W-1:0] rf_read_addr_a;
    logic [ADDR_W-1:0] rf_read_addr_b;
    logic [DATA_W-1:0] rf_read_data_a;
    logic [DATA_W-1:0] rf_read_data_b;

    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_write_data;
    logic              rf_write_en;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm,
        input  cmd_ready,
        input  rf_read_addr_a, rf_read_addr_b,
        output rf_read_data_a, rf_read_data_b,
        input  rf_write_addr, rf_write_data, rf_write_en
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm,
        output cmd_ready,
        output rf_read_addr_a, rf_read_addr_b,
        input  rf_read_data_a, rf_read_data_b,
        output rf_write_addr, rf_write_data, rf_write_en
    );
endinterface

// File: rtl/rf_op_sequencer.sv
// -----------------------------------------------------------------------------
// rf_op_sequencer
// Executes one register-file ALU command at a time through a fixed
// IDLE -> READ -> EXEC -> WRITE sequence (4 cycles per command).
//
// Opcodes: 0 NOP, 1 LDI, 2 MOV, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR.
// rd is both destination and first source (A), rs is second source (B).
//
// Parameters
//   DATA_W  datapath width (matches register file data width)
//   ADDR_W  register address width
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous, active-high
//   bus         rf_op_sequencer_if.slave: command handshake + register file bus
//   done        one-cycle pulse in the WRITE cycle of every command
//   zero_flag   last non-NOP result was zero
//   carry_flag  carry (ADD) / borrow (SUB) of last result
//               (only when RF_SEQ_CARRY_EN is defined)
//
// Build option
//   RF_SEQ_CARRY_EN  adds carry_flag and its update logic.
// -----------------------------------------------------------------------------
module rf_op_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    rf_op_sequencer_if.slave     bus,
    output logic                 done,
    output logic                 zero_flag
`ifdef RF_SEQ_CARRY_EN
    ,
    output logic                 carry_flag
`endif
);

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_LDI = 3'd1;
    localparam logic [2:0] OP_MOV = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_XOR = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] opa_q;
    logic [DATA_W-1:0] opb_q;
    logic [DATA_W-1:0] result;

    // Result of an operation, arithmetic modulo 2^DATA_W.
    function automatic logic [DATA_W-1:0] alu_result(
        input logic [2:0]        op,
        input logic [DATA_W-1:0] imm,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] r;
        r = '0;
        case (op)
            OP_LDI:  r = imm;
            OP_MOV:  r = b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = '0;
        endcase
        return r;
    endfunction

`ifdef RF_SEQ_CARRY_EN
    // Carry-out for ADD, borrow (A < B unsigned) for SUB, cleared otherwise.
    function automatic logic carry_out(
        input logic [2:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W:0] sum;
        logic            c;
        sum = {1'b0, a} + {1'b0, b};
        case (op)
            OP_ADD:  c = sum[DATA_W];
            OP_SUB:  c = (a < b);
            default: c = 1'b0;
        endcase
        return c;
    endfunction
`endif

    assign result = alu_result(op_q, imm_q, opa_q, opb_q);

    // Operand and immediate capture: pure datapath, no reset needed.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.cmd_valid) begin
            imm_q <= bus.cmd_imm;
        end
        if (state == READ) begin
            opa_q <= bus.rf_read_data_a;
            opb_q <= bus.rf_read_data_b;
        end
    end

    // Control FSM. All outputs are registered; the values for the WRITE
    // cycle (write strobe, done, flags) are loaded on the EXEC->WRITE edge
    // so they appear together in the WRITE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            op_q               <= OP_NOP;
            bus.cmd_ready      <= 1'b1;
            bus.rf_read_addr_a <= '0;
            bus.rf_read_addr_b <= '0;
            bus.rf_write_addr  <= '0;
            bus.rf_write_data  <= '0;
            bus.rf_write_en    <= 1'b0;
            done               <= 1'b0;
            zero_flag          <= 1'b0;
`ifdef RF_SEQ_CARRY_EN
            carry_flag         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q               <= bus.cmd_op;
                        // Read addresses double as the captured rd/rs and
                        // hold them until the next accepted command.
                        bus.rf_read_addr_a <= bus.cmd_rd;
                        bus.rf_read_addr_b <= bus.cmd_rs;
                        bus.cmd_ready      <= 1'b0;
                        state              <= READ;
                    end
                end
                READ: begin
                    state <= EXEC;
                end
                EXEC: begin
                    done <= 1'b1;
                    // NOP walks the full sequence but writes nothing and
                    // leaves the flags alone.
                    if (op_q != OP_NOP) begin
                        bus.rf_write_en   <= 1'b1;
                        bus.rf_write_addr <= bus.rf_read_addr_a;
                        bus.rf_write_data <= result;
                        zero_flag         <= (result == '0);
`ifdef RF_SEQ_CARRY_EN
                        carry_flag        <= carry_out(op_q, opa_q, opb_q);
`endif
                    end
                    state <= WRITE;
                end
                WRITE: begin
                    bus.rf_write_en <= 1'b0;
                    done            <= 1'b0;
                    bus.cmd_ready   <= 1'b1;
                    state           <= IDLE;
                end
                default: begin
                    bus.rf_write_en <= 1'b0;
                    done            <= 1'b0;
                    bus.cmd_ready   <= 1'b1;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rf_op_sequencer
// Bench for rf_op_sequencer: register file model, directed vector table,
// multi-cycle corner sequences (held-valid NOPs, reset mid-command) and
// randomized commands checked against a behavioural model.
// Define RF_SEQ_CARRY_EN on both DUT and bench to include carry_flag.
// -----------------------------------------------------------------------------
module tb_rf_op_sequencer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int CLK_P  = 10;

    localparam int OP_NOP = 0;
    localparam int OP_LDI = 1;
    localparam int OP_MOV = 2;
    localparam int OP_ADD = 3;
    localparam int OP_SUB = 4;
    localparam int OP_AND = 5;
    localparam int OP_OR  = 6;
    localparam int OP_XOR = 7;

    logic clk = 1'b0;
    logic reset;
    logic done;
    logic zero_flag;
`ifdef RF_SEQ_CARRY_EN
    logic carry_flag;
`endif

    rf_op_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rf_op_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .done      (done),
        .zero_flag (zero_flag)
`ifdef RF_SEQ_CARRY_EN
        ,
        .carry_flag(carry_flag)
`endif
    );

    always #(CLK_P/2) clk = ~clk;

    // Register file: synchronous write, asynchronous read.
    logic [DATA_W-1:0] rf_mem [4];
    always @(posedge clk) begin
        if (bus.rf_write_en) rf_mem[bus.rf_write_addr] <= bus.rf_write_data;
    end
    assign bus.rf_read_data_a = rf_mem[bus.rf_read_addr_a];
    assign bus.rf_read_data_b = rf_mem[bus.rf_read_addr_b];

    int cyc      = 0;
    int we_cnt   = 0;
    int done_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.rf_write_en) we_cnt <= we_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    int total   = 0;
    int bad     = 0;
    int cmd_idx = 0;
    int last_acc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (cmd %0d): got 0x%0h expected 0x%0h", name, cmd_idx, act, exp);
        end
    endtask

    // Behavioural model: register contents and flags, plain integer arithmetic.
    int m_regs [4];
    bit m_zero  = 1'b0;
    bit m_carry = 1'b0;

    task automatic model_step(input int op, input int rd, input int rs, input int imm, output int res);
        int a;
        int b;
        bit c;
        a = m_regs[rd];
        b = m_regs[rs];
        res = 0;
        c = 1'b0;
        case (op)
            OP_LDI: res = imm;
            OP_MOV: res = b;
            OP_ADD: begin res = (a + b) % 256; c = (a + b) > 255; end
            OP_SUB: begin res = (a - b + 256) % 256; c = (a < b); end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            default: res = 0;
        endcase
        if (op != OP_NOP) begin
            m_regs[rd] = res;
            m_zero     = (res == 0);
            m_carry    = c;
        end
    endtask

    // Issue one command and follow it through its four cycles.
    // exp_gap < 0 skips the accept-spacing check.
    task automatic do_cmd(input int op, input int rd, input int rs, input int imm,
                          input int exp_data, input bit exp_zero, input bit exp_carry,
                          input bit hold, input int exp_gap);
        int waited;
        waited = 0;
        while (bus.cmd_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("ready_before_cmd", 32'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op[2:0];
        bus.cmd_rd    = rd[1:0];
        bus.cmd_rs    = rs[1:0];
        bus.cmd_imm   = imm[7:0];
        @(posedge clk); #1;
        if (exp_gap >= 0) check("accept_spacing", 32'(cyc - last_acc), 32'(exp_gap));
        last_acc = cyc;
        // Busy: command inputs carry garbage, valid optionally held high.
        bus.cmd_valid = hold;
        bus.cmd_op    = 3'($urandom);
        bus.cmd_rd    = 2'($urandom);
        bus.cmd_rs    = 2'($urandom);
        bus.cmd_imm   = 8'($urandom);
        // READ
        check("read_ready",  32'(bus.cmd_ready), 0);
        check("read_we",     32'(bus.rf_write_en), 0);
        check("read_done",   32'(done), 0);
        check("read_addr_a", 32'(bus.rf_read_addr_a), 32'(rd));
        check("read_addr_b", 32'(bus.rf_read_addr_b), 32'(rs));
        @(posedge clk); #1;
        bus.cmd_op  = 3'($urandom);
        bus.cmd_imm = 8'($urandom);
        // EXEC
        check("exec_ready", 32'(bus.cmd_ready), 0);
        check("exec_we",    32'(bus.rf_write_en), 0);
        check("exec_done",  32'(done), 0);
        @(posedge clk); #1;
        // WRITE
        check("write_done", 32'(done), 1);
        check("write_we",   32'(bus.rf_write_en), (op != OP_NOP) ? 1 : 0);
        if (op != OP_NOP) begin
            check("write_addr", 32'(bus.rf_write_addr), 32'(rd));
            check("write_data", 32'(bus.rf_write_data), 32'(exp_data));
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        // Back in IDLE
        check("idle_ready",  32'(bus.cmd_ready), 1);
        check("idle_done",   32'(done), 0);
        check("idle_we",     32'(bus.rf_write_en), 0);
        check("zero_flag",   32'(zero_flag), 32'(exp_zero));
`ifdef RF_SEQ_CARRY_EN
        check("carry_flag",  32'(carry_flag), 32'(exp_carry));
`endif
        check("rf_contents", 32'(rf_mem[rd]), 32'(m_regs[rd]));
        check("hold_addr_a", 32'(bus.rf_read_addr_a), 32'(rd));
        cmd_idx++;
    endtask

    typedef struct {
        int op;
        int rd;
        int rs;
        int imm;
        int exp_data;
        bit exp_zero;
        bit exp_carry;
        bit hold;
    } vec_t;

    vec_t tbl [17];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int res;
        int w0;
        int d0;
        int op;
        int rd;
        int rs;
        int imm;
        int gap;
        bit hold;

        //            op      rd rs imm   data  z  c  hold
        tbl[0]  = '{OP_LDI, 1, 0, 'h5A, 'h5A, 0, 0, 0};
        tbl[1]  = '{OP_LDI, 2, 0, 'h20, 'h20, 0, 0, 1};
        tbl[2]  = '{OP_LDI, 1, 3, 'hF0, 'hF0, 0, 0, 0};
        tbl[3]  = '{OP_ADD, 1, 2, 'h00, 'h10, 0, 1, 0};
        tbl[4]  = '{OP_LDI, 3, 0, 'h33, 'h33, 0, 0, 0};
        tbl[5]  = '{OP_SUB, 3, 3, 'h00, 'h00, 1, 0, 1};
        tbl[6]  = '{OP_LDI, 2, 0, 'h01, 'h01, 0, 0, 0};
        tbl[7]  = '{OP_XOR, 2, 2, 'h00, 'h00, 1, 0, 0};
        tbl[8]  = '{OP_LDI, 0, 1, 'h05, 'h05, 0, 0, 0};
        tbl[9]  = '{OP_SUB, 2, 0, 'h00, 'hFB, 0, 1, 0};
        tbl[10] = '{OP_NOP, 2, 1, 'h77, 'h00, 0, 1, 1};
        tbl[11] = '{OP_AND, 2, 1, 'h00, 'h10, 0, 0, 0};
        tbl[12] = '{OP_OR,  0, 3, 'h00, 'h05, 0, 0, 0};
        tbl[13] = '{OP_MOV, 3, 1, 'hAA, 'h10, 0, 0, 0};
        tbl[14] = '{OP_ADD, 3, 2, 'h00, 'h20, 0, 0, 1};
        tbl[15] = '{OP_AND, 0, 3, 'h00, 'h00, 1, 0, 0};
        tbl[16] = '{OP_NOP, 0, 0, 'h00, 'h00, 1, 0, 0};

        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_rd    = '0;
        bus.cmd_rs    = '0;
        bus.cmd_imm   = '0;
        for (int i = 0; i < 4; i++) m_regs[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check("rst_ready",   32'(bus.cmd_ready), 1);
        check("rst_we",      32'(bus.rf_write_en), 0);
        check("rst_done",    32'(done), 0);
        check("rst_zero",    32'(zero_flag), 0);
`ifdef RF_SEQ_CARRY_EN
        check("rst_carry",   32'(carry_flag), 0);
`endif
        check("rst_addr_a",  32'(bus.rf_read_addr_a), 0);
        check("rst_addr_b",  32'(bus.rf_read_addr_b), 0);
        check("rst_waddr",   32'(bus.rf_write_addr), 0);
        check("rst_wdata",   32'(bus.rf_write_data), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(bus.cmd_ready), 1);

        // Directed vectors, issued back to back
        for (int i = 0; i < 17; i++) begin
            model_step(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].imm, res);
            do_cmd(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].imm,
                   tbl[i].exp_data, tbl[i].exp_zero, tbl[i].exp_carry,
                   tbl[i].hold, (i == 0) ? -1 : 4);
        end

        // NOPs with cmd_valid held high through the busy cycles
        w0 = we_cnt;
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) begin
            model_step(OP_NOP, i, 3 - i, 'hC3, res);
            do_cmd(OP_NOP, i, 3 - i, 'hC3, 0, m_zero, m_carry, 1'b1, 4);
        end
        check("nop_done_count", 32'(done_cnt - d0), 3);
        check("nop_we_count",   32'(we_cnt - w0), 0);

        // Reset during EXEC of LDI r0,0xFF
        w0 = we_cnt;
        d0 = done_cnt;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'(OP_LDI);
        bus.cmd_rd    = 2'd0;
        bus.cmd_rs    = 2'd0;
        bus.cmd_imm   = 8'hFF;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("abort_ready", 32'(bus.cmd_ready), 1);
        check("abort_we",    32'(bus.rf_write_en), 0);
        check("abort_done",  32'(done), 0);
        check("abort_zero",  32'(zero_flag), 0);
        check("abort_waddr", 32'(bus.rf_write_addr), 0);
        check("abort_wdata", 32'(bus.rf_write_data), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("abort_ready_after", 32'(bus.cmd_ready), 1);
        check("abort_we_count",    32'(we_cnt - w0), 0);
        check("abort_done_count",  32'(done_cnt - d0), 0);
        check("abort_r0_kept",     32'(rf_mem[0]), 32'(m_regs[0]));
        m_zero  = 1'b0;
        m_carry = 1'b0;

        // Randomized commands against the model
        for (int i = 0; i < 40; i++) begin
            op   = int'($urandom_range(0, 7));
            rd   = int'($urandom_range(0, 3));
            rs   = int'($urandom_range(0, 3));
            imm  = int'($urandom_range(0, 255));
            hold = 1'($urandom_range(0, 1));
            gap  = int'($urandom_range(0, 2));
            repeat (gap) begin @(posedge clk); #1; end
            model_step(op, rd, rs, imm, res);
            do_cmd(op, rd, rs, imm, res, m_zero, m_carry, hold, (i == 0) ? -1 : 4 + gap);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
